// File: rtl/mont_loop_ctrl_pkg.sv
// mont_pkg: shared constants, state encoding and the digit-extraction helper
// for the digit-serial Montgomery loop controller.
//
// Contents
//   SIZE, RADIX, DIGITS, SPLIT : operand width, digit width, iteration count,
//                                lo/hi boundary of the two-cycle adder
//   PP_W, SUM_W, IDX_W, EXT_W  : derived widths
//   mloop_state_t              : controller FSM states
//   get_digit()                : digit i of b, zero-padded past the top of b
package mont_pkg;

    localparam int SIZE   = 3072;
    localparam int RADIX  = 78;
    localparam int DIGITS = 40;
    localparam int SPLIT  = 1536;

    localparam int PP_W  = SIZE + RADIX;
    localparam int SUM_W = SIZE + RADIX + 1;
    localparam int IDX_W = 6;
    localparam int EXT_W = DIGITS * RADIX;

    typedef enum logic [2:0] {
        IDLE,
        MREQ,
        ADDL,
        ADDH,
        FIRE,
        PWAIT,
        DONE
    } mloop_state_t;

    // DIGITS*RADIX is 48 bits wider than SIZE, so the last digit only carries
    // 30 real bits of b; padding b up front keeps the part-select in range.
    function automatic logic [RADIX-1:0] get_digit(input logic [SIZE-1:0] b,
                                                   input logic [IDX_W-1:0] i);
        logic [EXT_W-1:0] ext;
        ext = {{(EXT_W-SIZE){1'b0}}, b};
        return ext[i*RADIX +: RADIX];
    endfunction

endpackage

// File: rtl/mont_loop_ctrl_if.sv
// mont_loop_ctrl_if: all non-clock/reset signals of mont_loop_ctrl.
//
// Groups
//   host      : start, b -> busy, done, result
//   multiplier: mul_req, mul_digit -> mul_ack, mul_pp
//   phase_a   : pa_en, pa_a -> pa_en_out, pa_new_a
//   err       : watchdog error, only when MONT_LOOP_WDOG_EN is defined
// Modports: master = the controller, slave = its environment.
interface mont_loop_ctrl_if;
    import mont_pkg::*;

    logic              start;
    logic [SIZE-1:0]   b;
    logic              busy;
    logic              done;
    logic [SIZE-1:0]   result;
    logic              mul_req;
    logic [RADIX-1:0]  mul_digit;
    logic              mul_ack;
    logic [PP_W-1:0]   mul_pp;
    logic              pa_en;
    logic [SUM_W-1:0]  pa_a;
    logic              pa_en_out;
    logic [SIZE-1:0]   pa_new_a;
`ifdef MONT_LOOP_WDOG_EN
    logic              err;
`endif

    modport master (
        input  start, b, mul_ack, mul_pp, pa_en_out, pa_new_a,
        output busy, done, result, mul_req, mul_digit, pa_en, pa_a
`ifdef MONT_LOOP_WDOG_EN
        , output err
`endif
    );

    modport slave (
        output start, b, mul_ack, mul_pp, pa_en_out, pa_new_a,
        input  busy, done, result, mul_req, mul_digit, pa_en, pa_a
`ifdef MONT_LOOP_WDOG_EN
        , input err
`endif
    );

endinterface

// File: rtl/mont_loop_ctrl_split_add2.sv
// split_add2: two-cycle adder for acc + pp, low half first.
//
// Ports
//   clk, rst : clock, async active-high reset
//   lo_en    : add the low SPLIT bits and register the carry
//   hi_en    : add the upper bits plus the registered carry
//   acc      : running accumulator (SIZE bits)
//   pp       : partial product (SIZE+RADIX bits)
//   sum      : registered SIZE+RADIX+1 bit result; holds while neither
//              enable is set, so it can drive phase_a.a directly
module split_add2
    import mont_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             lo_en,
    input  logic             hi_en,
    input  logic [SIZE-1:0]  acc,
    input  logic [PP_W-1:0]  pp,
    output logic [SUM_W-1:0] sum
);

    localparam int HI_W = SUM_W - SPLIT;

    logic [SPLIT-1:0] sum_lo;
    logic [HI_W-1:0]  sum_hi;
    logic             carry;

    // Upper half is widened to the full top slice of sum; the extra bits
    // absorb the carry out so nothing can overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_lo <= '0;
            sum_hi <= '0;
            carry  <= 1'b0;
        end else begin
            if (lo_en) begin
                {carry, sum_lo} <= {1'b0, acc[SPLIT-1:0]} + {1'b0, pp[SPLIT-1:0]};
            end
            if (hi_en) begin
                sum_hi <= {{(HI_W-(SIZE-SPLIT)){1'b0}}, acc[SIZE-1:SPLIT]}
                        + {1'b0, pp[PP_W-1:SPLIT]}
                        + {{(HI_W-1){1'b0}}, carry};
            end
        end
    end

    assign sum = {sum_hi, sum_lo};

endmodule

// File: rtl/mont_loop_ctrl.sv
// mont_loop_ctrl: digit-serial Montgomery loop controller upstream of phase_a.
// Walks b one RADIX-bit digit at a time (LSD first): requests b_i*x from the
// multiplier, adds it to the accumulator, hands the sum to phase_a, and takes
// phase_a's new_a back as the next accumulator. After DIGITS digits the
// accumulator is presented on result with a one-cycle done.
//
// Ports
//   clk, rst : clock, async active-high reset
//   bus      : mont_loop_ctrl_if.master (host, multiplier, phase_a, err)
//
// Build option: MONT_LOOP_WDOG_EN adds a 16-bit wait watchdog and bus.err.
module mont_loop_ctrl
    import mont_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    mont_loop_ctrl_if.master bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    mloop_state_t     state;
    logic [IDX_W-1:0] idx;
    logic [SIZE-1:0]  b_reg;
    logic [SIZE-1:0]  acc;
    logic [PP_W-1:0]  pp;
    logic             mul_req;
    logic [RADIX-1:0] mul_digit;
    logic             pa_en;
    logic             busy;
    logic             done;
    logic [SIZE-1:0]  result;
    logic [SUM_W-1:0] sum;
`ifdef MONT_LOOP_WDOG_EN
    logic [15:0]      wd_cnt;
    logic             err;
`endif

    split_add2 u_add (
        .clk   (clk),
        .rst   (rst),
        .lo_en (state == ADDL),
        .hi_en (state == ADDH),
        .acc   (acc),
        .pp    (pp),
        .sum   (sum)
    );

    // Controller FSM. done and pa_en default low each cycle so they can only
    // ever be single-cycle pulses; pa_a comes straight from the adder's
    // registers, which stay frozen from ADDH until the next digit's ADDL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            b_reg     <= '0;
            acc       <= '0;
            pp        <= '0;
            mul_req   <= 1'b0;
            mul_digit <= '0;
            pa_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
`ifdef MONT_LOOP_WDOG_EN
            wd_cnt    <= '0;
            err       <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
            pa_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        b_reg     <= bus.b;
                        acc       <= '0;
                        idx       <= '0;
                        mul_req   <= 1'b1;
                        mul_digit <= get_digit(bus.b, '0);
                        busy      <= 1'b1;
                        state     <= MREQ;
`ifdef MONT_LOOP_WDOG_EN
                        wd_cnt    <= '0;
                        err       <= 1'b0;
`endif
                    end
                end
                MREQ: begin
                    if (bus.mul_ack) begin
                        pp      <= bus.mul_pp;
                        mul_req <= 1'b0;
                        state   <= ADDL;
                    end
`ifdef MONT_LOOP_WDOG_EN
                    else if (wd_cnt == 16'hFFFF) begin
                        mul_req <= 1'b0;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                ADDL: begin
                    state <= ADDH;
                end
                ADDH: begin
                    pa_en <= 1'b1;
                    state <= FIRE;
                end
                FIRE: begin
                    state <= PWAIT;
`ifdef MONT_LOOP_WDOG_EN
                    wd_cnt <= '0;
`endif
                end
                PWAIT: begin
                    if (bus.pa_en_out) begin
                        acc <= bus.pa_new_a;
                        if (idx == LAST_IDX) begin
                            result <= bus.pa_new_a;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx       <= idx + 1'b1;
                            mul_req   <= 1'b1;
                            mul_digit <= get_digit(b_reg, idx + 1'b1);
                            state     <= MREQ;
`ifdef MONT_LOOP_WDOG_EN
                            wd_cnt    <= '0;
`endif
                        end
                    end
`ifdef MONT_LOOP_WDOG_EN
                    else if (wd_cnt == 16'hFFFF) begin
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.result    = result;
    assign bus.mul_req   = mul_req;
    assign bus.mul_digit = mul_digit;
    assign bus.pa_en     = pa_en;
    assign bus.pa_a      = sum;
`ifdef MONT_LOOP_WDOG_EN
    assign bus.err       = err;
`endif

endmodule

// File: doc/mont_loop_ctrl.md
# mont_loop_ctrl

Digit-serial Montgomery loop controller that sits directly upstream of `phase_a`. It walks operand `b` one radix-78 digit at a time, least significant digit first. For each digit it requests the partial product `b_i*x` from an external multiplier and adds that product to the running accumulator. It then launches one `phase_a` reduction and takes `phase_a.new_a` back as the next accumulator. After the last digit it presents the Montgomery product.

## Interface

**Reset (already decided):** one clock; reset is asynchronous and active-high.

**Parameters**
- `Size`, 3072: modulus and operand width.
- `radix`, 78: digit width.
- `Digits`, 40: iteration count, ceil(Size/radix).

**Ports**
- `clk`  in  1: sole clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request; ignored while `busy`.
- `b`  in  Size: multiplier operand; sampled on accepted `start`.
- `busy`  out  1: high from accepted `start` through the `done` cycle.
- `done`  out  1: one-cycle pulse; `result` is valid.
- `result`  out  Size: final accumulator; held until the next accepted `start`.
- `mul_req`  out  1: partial-product request.
- `mul_digit`  out  radix: current digit of `b`.
- `mul_ack`  in  1: `mul_pp` valid this cycle.
- `mul_pp`  in  Size+radix: `mul_digit*x`.
- `pa_en`  out  1: enable pulse to `phase_a.en`.
- `pa_a`  out  Size+radix+1: operand to `phase_a.a`.
- `pa_en_out`  in  1: `phase_a` completion strobe.
- `pa_new_a`  in  Size: `phase_a` result.
- `err`  out  1: watchdog error; present only with `MONT_LOOP_WDOG_EN`.

## Operation

**Reset values:** all outputs are 0. State is IDLE, and `acc`, `idx`, `b_reg` are 0.

**States**
- IDLE: on `start`, latch `b` into `b_reg`, clear `acc` to 0, set `idx`=0, go to MREQ.
- MREQ: `mul_req`=1 and `mul_digit`=`b_reg[idx*radix +: radix]`. Digit 39 is zero-padded: only its 30 LSBs come from `b`. On `mul_ack`, register `mul_pp` into `pp` and go to ADDL.
- ADDL: `sum[1535:0]` = `acc[1535:0]` + `pp[1535:0]`; register the carry. Go to ADDH.
- ADDH: `sum[Size+radix:1536]` = `acc[Size-1:1536]` + `pp[Size+radix-1:1536]` + carry. `sum` has Size+radix+1 bits and no overflow is possible. Go to FIRE.
- FIRE: `pa_en`=1 for exactly one cycle, `pa_a`=`sum`. Go to PWAIT.
- PWAIT: `pa_en`=0. `pa_a` is held stable until `pa_en_out`. On `pa_en_out`, set `acc` = `pa_new_a`:
  - if `idx`==Digits-1, go to DONE;
  - otherwise increment `idx` and go to MREQ.
- DONE: `result`=`acc`, `done`=1 for one cycle, go to IDLE.

**Rules and boundary cases**
- `mul_req` stays high until the ack cycle, and `mul_digit` is stable while `mul_req` is high. An ack outside MREQ is ignored.
- A `pa_en_out` outside PWAIT is ignored.
- `start` during `busy` is dropped, with no effect on the current run.
- `rst` mid-operation aborts the run: IDLE, no `done`, `result` cleared.
- `pa_en` is low for at least 1 cycle between pulses, which guarantees a fresh rising edge at `phase_a`.

## Timing

- Accepted `start` at edge 0 → `mul_req` high from cycle 1.
- Per digit: (cycles to `mul_ack`) + 1 capture + 2 add + 1 FIRE + (`phase_a` latency up to `pa_en_out`) + 1.
  - With a zero-wait multiplier and `phase_a` latency Lp: 5+Lp cycles per digit.
- `done` asserts 1 cycle after the last PWAIT exit.
- `busy` falls in the cycle after `done`.
- `pa_a` must remain stable for at least 4 cycles after `pa_en`, because `phase_a` samples `a` three cycles after its edge detect. PWAIT holding guarantees this.

## Configuration

Macro `MONT_LOOP_WDOG_EN`.

**Defined:**
- 16-bit counter runs in MREQ and PWAIT and is cleared on each state entry.
- On reaching 65535: `err`=1 (sticky until `rst` or the next accepted `start`), FSM goes to IDLE, no `done`.

**Undefined:** no counter, no `err` port, and waits are unbounded.

## Structure

- Package `mont_pkg`:
  - constants `SIZE`, `RADIX`, `DIGITS`, `SPLIT`=1536;
  - state enum `mloop_state_t` (IDLE, MREQ, ADDL, ADDH, FIRE, PWAIT, DONE).
- One sub-module: `split_add2`, the two-cycle lo/hi adder with registered carry, used for ADDL/ADDH.

## Test plan

- **Zero operand:** `b`=0, stub multiplier returns `mul_pp`=0, stub `phase_a` returns `a[Size-1:0]` after 17 cycles → exactly 40 `mul_req` handshakes with `mul_digit`=0, 40 `pa_en` pulses, `result`=0, a single `done`.
- **Digit extraction:** `b`=all ones, multiplier echoes `mul_pp`=`mul_digit` → digits 0..38 = 2^78−1, digit 39 = 2^30−1. With the pass-through `phase_a`, `result` = 39*(2^78−1) + (2^30−1).
- **Carry across split:** `acc` = 2^1536−1 (injected via a first-pass `pa_new_a`), `pp`=1 → `pa_a` = 2^1536.
- **Back-pressure:** `mul_ack` delayed 7 cycles and `pa_en_out` delayed 30 cycles → `mul_digit` and `pa_a` stable throughout, `pa_en` high exactly one cycle per digit.
- **Abort and restart:** `rst` asserted during PWAIT of digit 12 → all outputs 0 next cycle. A following `start` runs a full 40-digit pass. A `start` sent while `busy` is ignored.
- **Watchdog (`MONT_LOOP_WDOG_EN`):** `pa_en_out` never asserted → `err`=1 after 65535 PWAIT cycles, `busy`=0, no `done`.
